// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit geometry, converter states and a digit-range check.
package bcd_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [3:0]  MAX_DIGIT  = 4'd9;
    localparam int unsigned MAX_DIGITS = 6;
    localparam int unsigned BCD_MAX_W  = DIGIT_W * MAX_DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd2b_state_t;

    // True when every digit of a (zero-extended) packed BCD word is 0..9.
    function automatic logic is_bcd_valid(input logic [BCD_MAX_W-1:0] word);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < int'(MAX_DIGITS); k++) begin
            if (word[k*DIGIT_W +: DIGIT_W] > MAX_DIGIT) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit at N bits, built from two shifts and adds.
module bcd_mac10 #(
    parameter int unsigned N = 14
) (
    input  logic [N-1:0] acc_i,
    input  logic [3:0]   digit_i,
    output logic [N-1:0] mac_c_o
);

    logic [N-1:0] acc_x8;
    logic [N-1:0] acc_x2;

    assign acc_x8  = acc_i << 3;
    assign acc_x2  = acc_i << 1;
    assign mac_c_o = acc_x8 + acc_x2 + N'(digit_i);

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: captures a packed BCD word, folds it
// MSD-first by Horner's rule one digit per clock, and hands out the result.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned N      = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [N-1:0]                bin_out,
    output logic                        err,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;

    // Reject parameter sets whose result width cannot hold the largest word.
    if ((DIGITS < 1) || (DIGITS > MAX_DIGITS) || ((64'd1 << N) <= MAX_VAL)) begin : g_param_chk
        $error("bcd_to_bin: need 1<=DIGITS<=6 and 2**N > 10**DIGITS-1");
    end

    bcd2b_state_t     state_q, state_d;
    logic [N-1:0]     acc_q,   acc_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [W-1:0]     word_q,  word_d;
    logic [N-1:0]     bin_q,   bin_d;
    logic             err_q,   err_d;

    logic [DIGIT_W-1:0] digit_c;
    logic [N-1:0]       mac_c;
    logic               word_ok_c;

    assign digit_c   = word_q[DIGIT_W*idx_q +: DIGIT_W];
    assign word_ok_c = is_bcd_valid(BCD_MAX_W'(bcd_in));

    bcd_mac10 #(.N(N)) u_mac10 (
        .acc_i   (acc_q),
        .digit_i (digit_c),
        .mac_c_o (mac_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    // Next-state: accept in IDLE, one Horner step per CONV clock, hold in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        word_d  = word_q;
        bin_d   = bin_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d = bcd_in;
                    acc_d  = '0;
                    idx_d  = IDX_W'(DIGITS - 1);
                    if (!word_ok_c) begin
                        bin_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                acc_d = mac_c;
                idx_d = idx_q - IDX_W'(1);
                if (idx_q == '0) begin
                    bin_d   = mac_c;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bin_out   = bin_q;
    assign err       = err_q;

endmodule
